// File: rtl/fp_op_sequencer_if.sv
// Avalon-MM register port for the FP operation sequencer.
// The master drives address/strobes/writedata; the slave returns registered readdata.
interface fp_op_sequencer_if;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata,
    input  readdata
  );

  modport slave (
    input  address, write, read, writedata,
    output readdata
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// Launches one FP operation per CTRL start and waits for the datapath, with a timeout.
// Define FP_OP_SEQUENCER_IRQ_EN to add the irq output and the IRQ_EN register at address 5.
module fp_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  fp_op_sequencer_if.slave    bus,
  output logic [31:0]         fp_a,
  output logic [31:0]         fp_b,
  output logic [1:0]          fp_op,
  output logic                fp_start,
  input  logic                fp_valid,
`ifdef FP_OP_SEQUENCER_IRQ_EN
  output logic                irq,
`endif
  input  logic [31:0]         fp_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [15:0] TMO  = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_n;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] result;
  logic [1:0]  opcode;
  logic [15:0] cnt;
  logic        timeout;
  logic        busy;
  logic        done;
  logic        wr_ok;
  logic        start;
  logic        rd_res;
  logic        tmo_hit;
  logic [31:0] rdata;
`ifdef FP_OP_SEQUENCER_IRQ_EN
  logic        irq_en;
`endif

  assign busy    = (state == S_ISSUE) || (state == S_WAIT);
  assign done    = (state == S_DONE);
  assign wr_ok   = bus.write && !busy;
  assign start   = wr_ok && (bus.address == 3'd2)
                   && bus.writedata[0];
  assign rd_res  = bus.read && (bus.address == 3'd4);
  // Fires in the WAIT cycle where the count reaches the limit.
  assign tmo_hit = (cnt + 16'd1) == TMO;

  assign fp_a     = opa;
  assign fp_b     = opb;
  assign fp_op    = opcode;
  assign fp_start = (state == S_ISSUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (fp_valid || tmo_hit) state_n = S_DONE;
      S_DONE: begin
        if (start)       state_n = S_ISSUE;
        else if (rd_res) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    unique case (bus.address)
      3'd0:    rdata = opa;
      3'd1:    rdata = opb;
      3'd2:    rdata = {29'd0, opcode, 1'b0};
      3'd3:    rdata = {29'd0, timeout, done, busy};
      3'd4:    rdata = result;
`ifdef FP_OP_SEQUENCER_IRQ_EN
      3'd5:    rdata = {31'd0, irq_en};
`endif
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa          <= '0;
      opb          <= '0;
      opcode       <= '0;
      result       <= '0;
      cnt          <= '0;
      timeout      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr_ok) begin
        unique case (bus.address)
          3'd0:    opa    <= bus.writedata;
          3'd1:    opb    <= bus.writedata;
          3'd2:    opcode <= bus.writedata[2:1];
          default: ;
        endcase
      end
      if (start) timeout <= 1'b0;
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 16'd1;
      // A result arriving on the timeout cycle wins over the abort.
      if (state == S_WAIT) begin
        if (fp_valid) begin
          result  <= fp_result;
          timeout <= 1'b0;
        end else if (tmo_hit) begin
          result  <= QNAN;
          timeout <= 1'b1;
        end
      end
      if (bus.read) bus.readdata <= rdata;
    end
  end

`ifdef FP_OP_SEQUENCER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && bus.address == 3'd5)
        irq_en <= bus.writedata[0];
      irq <= (state_n == S_DONE) && irq_en;
    end
  end
`endif

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed checks of the FP operation sequencer with TIMEOUT_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fp_op_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fp_a;
  logic [31:0] fp_b;
  logic [1:0]  fp_op;
  logic        fp_start;
  logic        fp_valid = 1'b0;
  logic [31:0] fp_result = '0;
`ifdef FP_OP_SEQUENCER_IRQ_EN
  logic        irq;
`endif
  int          n_cmp = 0;
  int          n_err = 0;
  int          starts = 0;
  int          s0;
  logic [31:0] rd;

  fp_op_sequencer_if bus ();

  fp_op_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_op     (fp_op),
    .fp_start  (fp_start),
    .fp_valid  (fp_valid),
`ifdef FP_OP_SEQUENCER_IRQ_EN
    .irq       (irq),
`endif
    .fp_result (fp_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fp_start) starts <= starts + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    d = bus.readdata;
  endtask

  task automatic dp_pulse(input logic [31:0] r);
    fp_valid  = 1'b1;
    fp_result = r;
    @(negedge clk);
    fp_valid  = 1'b0;
  endtask

  initial begin
    bus.address   = '0;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_fp_start", {31'd0, fp_start}, 32'h0);
    reset_n = 1'b1;
    bus_read(3'd3, rd);
    chk("rst_status", rd, 32'h0);
    bus_read(3'd0, rd);
    chk("rst_opa", rd, 32'h0);

    // Basic add completing after a few WAIT cycles
    bus_write(3'd0, 32'h3F80_0000);
    bus_write(3'd1, 32'h4000_0000);
    s0 = starts;
    bus_write(3'd2, 32'h1);
    chk("add_start_hi", {31'd0, fp_start}, 32'h1);
    chk("add_fp_op", {30'd0, fp_op}, 32'h0);
    chk("add_fp_a", fp_a, 32'h3F80_0000);
    chk("add_fp_b", fp_b, 32'h4000_0000);
    repeat (4) @(negedge clk);
    dp_pulse(32'h4040_0000);
    chk("add_one_start", starts - s0, 32'd1);
    bus_read(3'd3, rd);
    chk("add_status_done", rd, 32'h2);
    bus_read(3'd4, rd);
    chk("add_result", rd, 32'h4040_0000);
    bus_read(3'd3, rd);
    chk("add_status_idle", rd, 32'h0);
    dp_pulse(32'hFFFF_FFFF);
    bus_read(3'd4, rd);
    chk("stray_valid_ignored", rd, 32'h4040_0000);

    // Writes while busy are dropped
    s0 = starts;
    bus_write(3'd2, 32'h3);
    bus_write(3'd0, 32'hDEAD_BEEF);
    bus_write(3'd2, 32'h1);
    chk("busy_opa_kept", fp_a, 32'h3F80_0000);
    chk("busy_op_kept", {30'd0, fp_op}, 32'h1);
    dp_pulse(32'h1234_5678);
    chk("busy_one_start", starts - s0, 32'd1);
    bus_read(3'd4, rd);
    chk("busy_result", rd, 32'h1234_5678);

    // Timeout: DONE after exactly 8 WAIT cycles
    bus_write(3'd2, 32'h7);
    chk("tmo_fp_op", {30'd0, fp_op}, 32'h3);
    repeat (7) @(negedge clk);
    bus_read(3'd3, rd);
    chk("tmo_still_busy", rd, 32'h1);
    bus_read(3'd3, rd);
    chk("tmo_status", rd, 32'h6);
    bus_read(3'd2, rd);
    chk("tmo_ctrl_rd", rd, 32'h6);
    bus_read(3'd4, rd);
    chk("tmo_result", rd, 32'h7FC0_0000);
    bus_read(3'd3, rd);
    chk("tmo_sticky", rd, 32'h4);

    // Result on the timeout cycle wins; start also clears timeout
    bus_write(3'd2, 32'h5);
    repeat (8) @(negedge clk);
    dp_pulse(32'hAABB_CCDD);
    bus_read(3'd3, rd);
    chk("edge_status", rd, 32'h2);
    bus_read(3'd4, rd);
    chk("edge_result", rd, 32'hAABB_CCDD);

    // Restart from DONE without reading RESULT
    bus_write(3'd2, 32'h1);
    repeat (9) @(negedge clk);
    s0 = starts;
    bus_write(3'd2, 32'h1);
    chk("restart_pulse", {31'd0, fp_start}, 32'h1);
    @(negedge clk);
    dp_pulse(32'h0BAD_F00D);
    bus_read(3'd4, rd);
    chk("restart_result", rd, 32'h0BAD_F00D);

    // Unmapped addresses
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    chk("addr6_zero", rd, 32'h0);
`ifndef FP_OP_SEQUENCER_IRQ_EN
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, rd);
    chk("addr5_zero", rd, 32'h0);
`endif

    // Reset during WAIT abandons the op
    bus_write(3'd2, 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_start", {31'd0, fp_start}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    dp_pulse(32'h5555_5555);
    bus_read(3'd3, rd);
    chk("rst_mid_status", rd, 32'h0);
    bus_read(3'd4, rd);
    chk("rst_mid_result", rd, 32'h0);
    chk("rst_mid_fp_a", fp_a, 32'h0);

`ifdef FP_OP_SEQUENCER_IRQ_EN
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    chk("irq_en_rd", rd, 32'h1);
    bus_write(3'd2, 32'h1);
    repeat (2) @(negedge clk);
    dp_pulse(32'h1);
    chk("irq_set", {31'd0, irq}, 32'h1);
    bus_read(3'd4, rd);
    chk("irq_clr", {31'd0, irq}, 32'h0);
    bus_write(3'd5, 32'h0);
    bus_write(3'd2, 32'h1);
    repeat (2) @(negedge clk);
    dp_pulse(32'h2);
    chk("irq_masked", {31'd0, irq}, 32'h0);
    bus_read(3'd4, rd);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
